lv1b_type_decision: RTL and testbench

- Downstream neighbour of the lv1a pipeline.
- On each one-clock lv1b request, consumes the lv1a trigger-type bits, #clus and timestamp read from the lv1a memories, and decides whether the event becomes an lv1 (nclus cut plus per-class prescale).
- Accepted events are issued as a one-clock lv1 pulse a fixed latency later.
- Drives the lv1 inhibit back upstream so that a pre-lv1 is never granted in the window around a pending lv1.

---
 rtl/lv1b_type_decision.sv | 179 +++++++++++++++++
 tb/tb_lv1b_type_decision.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lv1b_type_decision.sv
`default_nettype none
// ============================================================================
// Module      : lv1b_type_decision
// Description : Decides whether an lv1b request becomes an lv1 (nclus cut plus
//               per-class prescale), schedules accepted events through a
//               fixed-latency delay line and pending-event FIFO, issues the lv1
//               pulse with the stored event data, and drives the lv1 inhibit
//               back to the lv1a pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module lv1b_type_decision #(
    parameter int LV1_DELAY   = 64,
    parameter int INHIBIT_WIN = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_live,
    input  logic        in_lv1b_req,
    input  logic [3:0]  in_nclus,
    input  logic [7:0]  in_int_lv1a,
    input  logic [3:0]  in_ext_lv1a,
    input  logic        in_delta_lv1a,
    input  logic [31:0] in_timestamp,
    input  logic [3:0]  nclus_min,
    input  logic [15:0] ps_int,
    input  logic [15:0] ps_ext,
    input  logic [15:0] ps_delta,
    output logic        out_lv1,
    output logic        out_lv1_inhibit,
    output logic [12:0] out_lv1_trig,
    output logic [3:0]  out_lv1_nclus,
    output logic [31:0] out_lv1_timestamp,
    output logic [31:0] lv1_cnt,
    output logic [31:0] lv1b_rej_cnt,
    output logic        lv1_ovf_err
);

    localparam int             c_AW       = $clog2(FIFO_DEPTH);
    localparam int             c_EW       = 49;
    localparam logic [c_AW-1:0] c_PTR_ONE = 1;
    localparam logic [c_AW:0]   c_FULL    = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE = 1;

    logic [LV1_DELAY-1:0] r_dl;
    logic [LV1_DELAY-1:0] w_dl_next;
    logic [c_EW-1:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_AW:0]        r_count;
    logic [15:0]          r_ps_cnt [3];
    logic [15:0]          w_ps_cnt_nxt [3];
    logic [15:0]          w_ps [3];
    logic [2:0]           w_cand;
    logic [2:0]           w_pass;
    logic                 r_live_prev;
    logic                 r_lv1;
    logic                 r_inhibit;
    logic [12:0]          r_trig;
    logic [3:0]           r_nclus;
    logic [31:0]          r_ts;
    logic [31:0]          r_lv1_cnt;
    logic [31:0]          r_rej_cnt;
    logic                 r_ovf;

    logic w_req, w_accept, w_full, w_push, w_drop, w_issue, w_pop, w_live_rise;
    logic w_inhibit_next;

    // Class candidates and prescale decision for the current request
    always_comb begin
        w_cand[0] = (in_int_lv1a != 8'd0) && (in_nclus >= nclus_min);
        w_cand[1] = (in_ext_lv1a != 4'd0);
        w_cand[2] = in_delta_lv1a;
        w_ps[0]   = ps_int;
        w_ps[1]   = ps_ext;
        w_ps[2]   = ps_delta;
        for (int i = 0; i < 3; i++) begin
            w_pass[i]       = 1'b0;
            w_ps_cnt_nxt[i] = r_ps_cnt[i];
            // A zero prescale disables the class and freezes its counter
            if (w_req && w_cand[i] && (w_ps[i] != 16'd0)) begin
                if (r_ps_cnt[i] == (w_ps[i] - 16'd1)) begin
                    w_pass[i]       = 1'b1;
                    w_ps_cnt_nxt[i] = 16'd0;
                end else begin
                    w_ps_cnt_nxt[i] = r_ps_cnt[i] + 16'd1;
                end
            end
        end
    end

    // Accept / push / issue control; inhibit is computed from the next delay-line state
    always_comb begin
        w_req          = in_live & in_lv1b_req;
        w_live_rise    = in_live & ~r_live_prev;
        w_accept       = w_req & (|w_pass);
        w_full         = (r_count == c_FULL);
        w_push         = w_accept & ~w_full;
        w_drop         = w_accept & w_full;
        w_issue        = in_live & r_dl[LV1_DELAY-1];
        w_pop          = w_issue & (r_count != '0);
        w_dl_next      = in_live ? {r_dl[LV1_DELAY-2:0], w_push} : '0;
        w_inhibit_next = in_live &
                         ((|w_dl_next[LV1_DELAY-1 -: INHIBIT_WIN+1]) | w_issue);
    end

    // Delay line, FIFO pointers, prescale counters and pulse/inhibit registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dl        <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_live_prev <= 1'b0;
            r_lv1       <= 1'b0;
            r_inhibit   <= 1'b0;
            for (int i = 0; i < 3; i++) r_ps_cnt[i] <= 16'd0;
        end else begin
            r_live_prev <= in_live;
            r_dl        <= w_dl_next;
            r_lv1       <= w_issue;
            r_inhibit   <= w_inhibit_next;
            if (!in_live) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                for (int i = 0; i < 3; i++) r_ps_cnt[i] <= 16'd0;
            end else begin
                for (int i = 0; i < 3; i++) r_ps_cnt[i] <= w_ps_cnt_nxt[i];
                if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                if (w_push && !w_pop)      r_count <= r_count + c_CNT_ONE;
                else if (!w_push && w_pop) r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Event storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {in_delta_lv1a, in_ext_lv1a, in_int_lv1a,
                                        in_nclus, in_timestamp};
    end

    // Issued-event data, held until the next issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig  <= '0;
            r_nclus <= '0;
            r_ts    <= '0;
        end else if (w_pop) begin
            {r_trig, r_nclus, r_ts} <= r_mem[r_rd_ptr];
        end
    end

    // Statistics; cleared on the live rising edge, frozen while not live
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lv1_cnt <= '0;
            r_rej_cnt <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_lv1_cnt <= (w_live_rise ? 32'd0 : r_lv1_cnt) + {31'd0, w_issue};
            r_rej_cnt <= (w_live_rise ? 32'd0 : r_rej_cnt) +
                         {31'd0, (w_req & ~w_accept) | w_drop};
            r_ovf     <= (w_live_rise ? 1'b0 : r_ovf) | w_drop;
        end
    end

    assign out_lv1           = r_lv1;
    assign out_lv1_inhibit   = r_inhibit;
    assign out_lv1_trig      = r_trig;
    assign out_lv1_nclus     = r_nclus;
    assign out_lv1_timestamp = r_ts;
    assign lv1_cnt           = r_lv1_cnt;
    assign lv1b_rej_cnt      = r_rej_cnt;
    assign lv1_ovf_err       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_lv1b_type_decision.sv
`default_nettype none
// ============================================================================
// Module      : tb_lv1b_type_decision
// Description : Self-checking bench for lv1b_type_decision. Instance A uses the
//               default parameters, instance B a 200-cycle delay to exercise
//               FIFO overflow. Expected lv1 events are queued when requests are
//               driven and compared when the pulse appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lv1b_type_decision;

    localparam int c_DA = 64;
    localparam int c_DB = 200;

    typedef struct {
        logic [12:0] trig;
        logic [3:0]  nclus;
        logic [31:0] ts;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        live = 1'b0;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic [3:0]  nclus = '0;
    logic [7:0]  int_t = '0;
    logic [3:0]  ext_t = '0;
    logic        dlt = 1'b0;
    logic [31:0] ts = '0;
    logic [3:0]  nclus_min = '0;
    logic [15:0] ps_int = '0, ps_ext = '0, ps_delta = '0;

    logic        lv1_a, inh_a, ovf_a, lv1_b, inh_b, ovf_b;
    logic [12:0] trig_a, trig_b;
    logic [3:0]  ncl_a, ncl_b;
    logic [31:0] ts_a, ts_b, cnt_a, cnt_b, rej_a, rej_b;

    exp_t        qa[$];
    exp_t        qb[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    // Edge counter: after edge E the value reads E
    always @(posedge clk) cyc <= cyc + 1;

    lv1b_type_decision #(.LV1_DELAY(c_DA), .INHIBIT_WIN(4), .FIFO_DEPTH(4)) u_dut_a (
        .clk(clk), .rst(rst), .in_live(live), .in_lv1b_req(req_a),
        .in_nclus(nclus), .in_int_lv1a(int_t), .in_ext_lv1a(ext_t),
        .in_delta_lv1a(dlt), .in_timestamp(ts), .nclus_min(nclus_min),
        .ps_int(ps_int), .ps_ext(ps_ext), .ps_delta(ps_delta),
        .out_lv1(lv1_a), .out_lv1_inhibit(inh_a), .out_lv1_trig(trig_a),
        .out_lv1_nclus(ncl_a), .out_lv1_timestamp(ts_a), .lv1_cnt(cnt_a),
        .lv1b_rej_cnt(rej_a), .lv1_ovf_err(ovf_a)
    );

    lv1b_type_decision #(.LV1_DELAY(c_DB), .INHIBIT_WIN(4), .FIFO_DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .in_live(live), .in_lv1b_req(req_b),
        .in_nclus(nclus), .in_int_lv1a(int_t), .in_ext_lv1a(ext_t),
        .in_delta_lv1a(dlt), .in_timestamp(ts), .nclus_min(nclus_min),
        .ps_int(ps_int), .ps_ext(ps_ext), .ps_delta(ps_delta),
        .out_lv1(lv1_b), .out_lv1_inhibit(inh_b), .out_lv1_trig(trig_b),
        .out_lv1_nclus(ncl_b), .out_lv1_timestamp(ts_b), .lv1_cnt(cnt_b),
        .lv1b_rej_cnt(rej_b), .lv1_ovf_err(ovf_b)
    );

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one request on instance A (sel=0) or B (sel=1); queue it if it should issue
    task automatic drive_req(input bit sel, input logic [7:0] it, input logic [3:0] et,
                             input logic d, input logic [3:0] nc, input logic [31:0] t,
                             input bit expect_issue);
        exp_t e;
        @(negedge clk);
        int_t = it; ext_t = et; dlt = d; nclus = nc; ts = t;
        if (sel) req_b = 1'b1; else req_a = 1'b1;
        if (expect_issue) begin
            e.trig  = {d, et, it};
            e.nclus = nc;
            e.ts    = t;
            e.cyc   = cyc + 1 + (sel ? c_DB : c_DA);
            if (sel) qb.push_back(e); else qa.push_back(e);
        end
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0;
    endtask

    task automatic test_reset;
        wait_cycles(3);
        n_cmp++;
        if ({lv1_a, inh_a, ovf_a, lv1_b, inh_b, ovf_b} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags got=%b exp=000000", {lv1_a, inh_a, ovf_a, lv1_b, inh_b, ovf_b});
        end
        n_cmp++;
        if ({trig_a, ncl_a, ts_a} !== 49'd0) begin
            n_bad++;
            $display("FAIL reset_data got=%h exp=0", {trig_a, ncl_a, ts_a});
        end
        n_cmp++;
        if ({cnt_a, rej_a, cnt_b, rej_b} !== 128'd0) begin
            n_bad++;
            $display("FAIL reset_counters got=%h exp=0", {cnt_a, rej_a, cnt_b, rej_b});
        end
        @(negedge clk);
        rst = 1'b0;
        live = 1'b1;
        wait_cycles(2);
    endtask

    task automatic test_int_accept;
        exp_t        e;
        int unsigned t;
        bit          exp_inh;
        ps_int = 16'd1; nclus_min = 4'd3; ps_ext = 16'd0; ps_delta = 16'd0;
        @(negedge clk);
        int_t = 8'h01; ext_t = 4'h0; dlt = 1'b0; nclus = 4'd4; ts = 32'h1234;
        req_a = 1'b1;
        t = cyc + 1;
        e.trig = 13'h0001; e.nclus = 4'd4; e.ts = 32'h1234; e.cyc = t + c_DA;
        qa.push_back(e);
        @(negedge clk);
        req_a = 1'b0;
        while (cyc <= t + c_DA + 2) begin
            if (cyc >= t + c_DA - 8) begin
                exp_inh = (cyc >= t + 59) && (cyc <= t + 64);
                n_cmp++;
                if (inh_a !== exp_inh) begin
                    n_bad++;
                    $display("FAIL inhibit_window cyc=t+%0d got=%b exp=%b", cyc - t, inh_a, exp_inh);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (cnt_a !== 32'd1) begin
            n_bad++;
            $display("FAIL int_lv1_cnt got=%0d exp=1", cnt_a);
        end
    endtask

    task automatic test_nclus_cut;
        drive_req(1'b0, 8'h01, 4'h0, 1'b0, 4'd2, 32'h1234, 1'b0);
        wait_cycles(c_DA + 6);
        n_cmp++;
        if (rej_a !== 32'd1 || cnt_a !== 32'd1) begin
            n_bad++;
            $display("FAIL nclus_cut rej=%0d cnt=%0d exp rej=1 cnt=1", rej_a, cnt_a);
        end
    endtask

    task automatic test_live_drop;
        drive_req(1'b0, 8'h10, 4'h0, 1'b0, 4'd5, 32'hABCD, 1'b1);
        wait_cycles(10);
        live = 1'b0;
        @(negedge clk);
        qa.delete();
        drive_req(1'b0, 8'h10, 4'h0, 1'b0, 4'd5, 32'h5555, 1'b0);
        n_cmp++;
        if (inh_a !== 1'b0 || lv1_a !== 1'b0) begin
            n_bad++;
            $display("FAIL live_low_outputs inh=%b lv1=%b exp 0 0", inh_a, lv1_a);
        end
        n_cmp++;
        if (cnt_a !== 32'd1 || rej_a !== 32'd1) begin
            n_bad++;
            $display("FAIL live_low_hold cnt=%0d rej=%0d exp cnt=1 rej=1", cnt_a, rej_a);
        end
        wait_cycles(3);
        live = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cnt_a !== 32'd0 || rej_a !== 32'd0 || ovf_a !== 1'b0) begin
            n_bad++;
            $display("FAIL live_rise_clear cnt=%0d rej=%0d ovf=%b exp 0 0 0", cnt_a, rej_a, ovf_a);
        end
        wait_cycles(c_DA + 10);
        n_cmp++;
        if (cnt_a !== 32'd0) begin
            n_bad++;
            $display("FAIL live_drop_discard cnt=%0d exp=0", cnt_a);
        end
    endtask

    task automatic test_ext_prescale;
        ps_ext = 16'd3;
        for (int i = 1; i <= 9; i++) begin
            drive_req(1'b0, 8'h00, 4'h2, 1'b0, 4'd1, 32'h100 + i, (i % 3) == 0);
            wait_cycles(18);
        end
        wait_cycles(c_DA + 4);
        n_cmp++;
        if (cnt_a !== 32'd3) begin
            n_bad++;
            $display("FAIL ext_prescale_cnt got=%0d exp=3", cnt_a);
        end
        n_cmp++;
        if (rej_a !== 32'd6) begin
            n_bad++;
            $display("FAIL ext_prescale_rej got=%0d exp=6", rej_a);
        end
        ps_ext = 16'd0;
    endtask

    task automatic test_fifo_overflow;
        ps_int = 16'd1; nclus_min = 4'd0;
        for (int i = 0; i < 6; i++) begin
            drive_req(1'b1, 8'h04, 4'h0, 1'b0, 4'(i + 1), 32'hB000 + i, i < 4);
            wait_cycles(18);
        end
        n_cmp++;
        if (ovf_b !== 1'b1 || rej_b !== 32'd2) begin
            n_bad++;
            $display("FAIL fifo_overflow ovf=%b rej=%0d exp ovf=1 rej=2", ovf_b, rej_b);
        end
        wait_cycles(c_DB);
        n_cmp++;
        if (cnt_b !== 32'd4 || qb.size() != 0) begin
            n_bad++;
            $display("FAIL fifo_issued cnt=%0d pending=%0d exp cnt=4 pending=0", cnt_b, qb.size());
        end
    endtask

    task automatic test_reset_mid_run;
        ps_int = 16'd1;
        drive_req(1'b0, 8'h80, 4'h0, 1'b0, 4'd7, 32'hC001, 1'b1);
        wait_cycles(3);
        drive_req(1'b0, 8'h40, 4'h0, 1'b0, 4'd6, 32'hC002, 1'b1);
        wait_cycles(10);
        #2;
        qa.delete();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({lv1_a, inh_a, ovf_a, trig_a, ncl_a, ts_a, cnt_a, rej_a} !== 116'd0) begin
            n_bad++;
            $display("FAIL reset_mid_run cnt=%0d rej=%0d trig=%h ts=%h exp all 0", cnt_a, rej_a, trig_a, ts_a);
        end
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(c_DA + 10);
        n_cmp++;
        if (cnt_a !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_no_issue cnt=%0d exp=0", cnt_a);
        end
    endtask

    initial begin
        // Scoreboard: every cycle, the pulse must match the queue head's due cycle
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    bit ea, eb;
                    ea = (qa.size() > 0) && (qa[0].cyc == cyc);
                    eb = (qb.size() > 0) && (qb[0].cyc == cyc);
                    n_cmp++;
                    if (lv1_a !== ea) begin
                        n_bad++;
                        $display("FAIL lv1_pulse_a cyc=%0d got=%b exp=%b", cyc, lv1_a, ea);
                    end
                    n_cmp++;
                    if (lv1_b !== eb) begin
                        n_bad++;
                        $display("FAIL lv1_pulse_b cyc=%0d got=%b exp=%b", cyc, lv1_b, eb);
                    end
                    if (ea) begin
                        n_cmp++;
                        if ({trig_a, ncl_a, ts_a} !== {qa[0].trig, qa[0].nclus, qa[0].ts}) begin
                            n_bad++;
                            $display("FAIL lv1_data_a got=%h/%h/%h exp=%h/%h/%h", trig_a, ncl_a, ts_a,
                                     qa[0].trig, qa[0].nclus, qa[0].ts);
                        end
                        void'(qa.pop_front());
                    end
                    if (eb) begin
                        n_cmp++;
                        if ({trig_b, ncl_b, ts_b} !== {qb[0].trig, qb[0].nclus, qb[0].ts}) begin
                            n_bad++;
                            $display("FAIL lv1_data_b got=%h/%h/%h exp=%h/%h/%h", trig_b, ncl_b, ts_b,
                                     qb[0].trig, qb[0].nclus, qb[0].ts);
                        end
                        void'(qb.pop_front());
                    end
                end
            end
        join_none

        test_reset();
        test_int_accept();
        test_nclus_cut();
        test_live_drop();
        test_ext_prescale();
        test_fifo_overflow();
        test_reset_mid_run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
